// File: rtl/booth_multiplier_n.sv
// Purpose : sequential radix-2 Booth multiplier, signed or unsigned WIDTH x WIDTH -> 2*WIDTH.
// Latency : start accepted at edge E0 -> finish pulses in the cycle after edge E0+WIDTH+1.
// Backpressure: none; start is ignored while busy or finishing, interrupt aborts a running op.
//
// Ports:
//   clk, reset_n           : clock and synchronous active-low reset
//   start, interrupt       : operation request / abort request, sampled every edge
//   signed_mode            : 1 = two's-complement operands, 0 = unsigned
//   operand_a, operand_b   : multiplicand / multiplier, captured on an accepted start
//   result, result_hi      : low / high halves of the product, held until the next start
//   busy, finish, overflow : running flag, one-cycle done pulse, product exceeds WIDTH bits
module booth_multiplier_n #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             interrupt,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             busy,
  output logic             finish,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH + 2);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic             mode_q;
  // Multiplicand is kept at WIDTH+2 bits so that negating the most negative
  // (WIDTH+1)-bit value cannot overflow the accumulator.
  logic [WIDTH+1:0] mcand;
  logic [WIDTH+1:0] acc;
  logic [WIDTH:0]   mplr;
  logic             q_m1;

  logic [WIDTH+1:0] sum;
  logic [WIDTH+1:0] acc_nxt;
  logic [WIDTH:0]   mplr_nxt;
  logic [WIDTH-1:0] prod_lo;
  logic [WIDTH-1:0] prod_hi;
  logic             ovf_nxt;
  logic             ext_a;
  logic             ext_b;

  assign ext_a = signed_mode & operand_a[WIDTH-1];
  assign ext_b = signed_mode & operand_b[WIDTH-1];

  // One Booth step: add/subtract per {q0, q-1}, then arithmetic shift of {acc, mplr}.
  always_comb begin
    sum = acc;
    case ({mplr[0], q_m1})
      2'b01:   sum = acc + mcand;
      2'b10:   sum = acc - mcand;
      default: sum = acc;
    endcase
    acc_nxt  = {sum[WIDTH+1], sum[WIDTH+1:1]};
    mplr_nxt = {sum[0], mplr[WIDTH:1]};
    // After the last step the exact product occupies the low 2*WIDTH bits of {acc, mplr}.
    prod_lo  = mplr_nxt[WIDTH-1:0];
    prod_hi  = {acc_nxt[WIDTH-2:0], mplr_nxt[WIDTH]};
    ovf_nxt  = mode_q ? (prod_hi != {WIDTH{prod_lo[WIDTH-1]}}) : (prod_hi != '0);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      mode_q    <= 1'b0;
      mcand     <= '0;
      acc       <= '0;
      mplr      <= '0;
      q_m1      <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !interrupt) begin
            mode_q <= signed_mode;
            mcand  <= {ext_a, ext_a, operand_a};
            mplr   <= {ext_b, operand_b};
            acc    <= '0;
            q_m1   <= 1'b0;
            cnt    <= CW'(WIDTH + 1);
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          if (interrupt) begin
            state     <= S_IDLE;
            cnt       <= '0;
            result    <= '0;
            result_hi <= '0;
            overflow  <= 1'b0;
          end else begin
            acc  <= acc_nxt;
            mplr <= mplr_nxt;
            q_m1 <= mplr[0];
            cnt  <= cnt - 1'b1;
            if (cnt == CW'(1)) begin
              state     <= S_DONE;
              result    <= prod_lo;
              result_hi <= prod_hi;
              overflow  <= ovf_nxt;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy   = (state == S_RUN);
  assign finish = (state == S_DONE);

endmodule

// File: tb/tb_booth_multiplier_n.sv
module tb_booth_multiplier_n;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        interrupt;
  logic        signed_mode;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [31:0] result;
  logic [31:0] result_hi;
  logic        busy;
  logic        finish;
  logic        overflow;

  logic        start8;
  logic        sm8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic [7:0]  result8;
  logic [7:0]  result_hi8;
  logic        busy8;
  logic        finish8;
  logic        overflow8;

  int tests_run;
  int fails;

  booth_multiplier_n #(.WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .interrupt(interrupt),
    .signed_mode(signed_mode), .operand_a(operand_a), .operand_b(operand_b),
    .result(result), .result_hi(result_hi), .busy(busy), .finish(finish),
    .overflow(overflow)
  );

  booth_multiplier_n #(.WIDTH(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .start(start8), .interrupt(interrupt),
    .signed_mode(sm8), .operand_a(a8), .operand_b(b8),
    .result(result8), .result_hi(result_hi8), .busy(busy8), .finish(finish8),
    .overflow(overflow8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launches one operation on the 32-bit instance. lat = edges after E0 until
  // finish is seen (-1 on timeout), bcnt = cycles with busy high, fin2 = finish
  // one cycle after the pulse. Operands are scrambled right after capture.
  task automatic run32(input logic sm, input logic [31:0] a, input logic [31:0] b,
                       input bit mid_start, output int lat, output int bcnt,
                       output logic fin2);
    bit done;
    @(negedge clk);
    signed_mode = sm; operand_a = a; operand_b = b; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; operand_a = $urandom; operand_b = $urandom; signed_mode = ~sm;
    lat = 0; bcnt = 0; done = 0;
    while (!done && lat < 100) begin
      if (finish) done = 1;
      else begin
        if (busy) bcnt++;
        if (mid_start && lat == 15) begin
          start = 1'b1; operand_a = 32'd999; operand_b = 32'd5;
        end else start = 1'b0;
        @(posedge clk); @(negedge clk); lat++;
      end
    end
    start = 1'b0;
    if (!done) lat = -1;
    @(negedge clk);
    fin2 = finish;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; start = 1'b1; interrupt = 1'b1; start8 = 1'b1;
    signed_mode = 0; operand_a = 5; operand_b = 5; sm8 = 0; a8 = 3; b8 = 3;
    repeat (3) @(negedge clk);
    tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
    tests_run++; if (finish !== 1'b0) begin fails++; $display("FAIL reset_finish got=%b exp=0", finish); end
    tests_run++; if ({result_hi, result, overflow} !== 65'd0) begin fails++;
      $display("FAIL reset_outputs got hi=%h lo=%h ovf=%b exp=0", result_hi, result, overflow); end
    tests_run++; if ({busy8, finish8, overflow8, result_hi8, result8} !== 19'd0) begin fails++;
      $display("FAIL reset_outputs8 got busy=%b fin=%b hi=%h lo=%h exp=0", busy8, finish8, result_hi8, result8); end
    start = 0; interrupt = 0; start8 = 0;
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_unsigned_small;
    int lat; int bcnt; logic fin2;
    run32(1'b0, 32'd7, 32'd6, 1'b0, lat, bcnt, fin2);
    tests_run++; if (lat !== 33) begin fails++; $display("FAIL u7x6_latency got=%0d exp=33", lat); end
    tests_run++; if (bcnt !== 33) begin fails++; $display("FAIL u7x6_busy_cycles got=%0d exp=33", bcnt); end
    tests_run++; if (fin2 !== 1'b0) begin fails++; $display("FAIL u7x6_finish_pulse got=%b exp=0", fin2); end
    tests_run++; if ({result_hi, result, overflow} !== {32'd0, 32'd42, 1'b0}) begin fails++;
      $display("FAIL u7x6_product got hi=%h lo=%h ovf=%b exp hi=0 lo=2a ovf=0", result_hi, result, overflow); end
  endtask

  task automatic test_signed_neg;
    int lat; int bcnt; logic fin2;
    run32(1'b1, 32'hFFFFFFFD, 32'd5, 1'b0, lat, bcnt, fin2);
    tests_run++; if ({result_hi, result, overflow} !== {32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0}) begin fails++;
      $display("FAIL s_m3x5 got hi=%h lo=%h ovf=%b exp hi=ffffffff lo=fffffff1 ovf=0", result_hi, result, overflow); end
    tests_run++; if (lat !== 33) begin fails++; $display("FAIL s_m3x5_latency got=%0d exp=33", lat); end
  endtask

  task automatic test_overflow;
    int lat; int bcnt; logic fin2;
    run32(1'b0, 32'h00010000, 32'h00010000, 1'b0, lat, bcnt, fin2);
    tests_run++; if ({result_hi, result, overflow} !== {32'd1, 32'd0, 1'b1}) begin fails++;
      $display("FAIL u_2p32 got hi=%h lo=%h ovf=%b exp hi=1 lo=0 ovf=1", result_hi, result, overflow); end
    run32(1'b1, 32'h00010000, 32'h00010000, 1'b0, lat, bcnt, fin2);
    tests_run++; if ({result_hi, result, overflow} !== {32'd1, 32'd0, 1'b1}) begin fails++;
      $display("FAIL s_2p32 got hi=%h lo=%h ovf=%b exp hi=1 lo=0 ovf=1", result_hi, result, overflow); end
  endtask

  task automatic test_extremes;
    int lat; int bcnt; logic fin2;
    run32(1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b0, lat, bcnt, fin2);
    tests_run++; if ({result_hi, result, overflow} !== {32'd0, 32'h80000000, 1'b1}) begin fails++;
      $display("FAIL s_min_x_m1 got hi=%h lo=%h ovf=%b exp hi=0 lo=80000000 ovf=1", result_hi, result, overflow); end
    run32(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, lat, bcnt, fin2);
    tests_run++; if ({result_hi, result, overflow} !== {32'hFFFFFFFE, 32'd1, 1'b1}) begin fails++;
      $display("FAIL u_max_sq got hi=%h lo=%h ovf=%b exp hi=fffffffe lo=1 ovf=1", result_hi, result, overflow); end
  endtask

  task automatic test_interrupt;
    int nfin;
    @(negedge clk);
    signed_mode = 0; operand_a = 32'd1000; operand_b = 32'd1000; start = 1'b1;
    @(posedge clk); @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    tests_run++; if (busy !== 1'b1) begin fails++; $display("FAIL irq_busy_before got=%b exp=1", busy); end
    interrupt = 1'b1;
    @(negedge clk); interrupt = 1'b0;
    tests_run++; if ({busy, finish} !== 2'b00) begin fails++;
      $display("FAIL irq_busy_after got busy=%b fin=%b exp 0 0", busy, finish); end
    tests_run++; if ({result_hi, result, overflow} !== 65'd0) begin fails++;
      $display("FAIL irq_outputs got hi=%h lo=%h ovf=%b exp=0", result_hi, result, overflow); end
    nfin = 0;
    repeat (40) begin @(negedge clk); if (finish) nfin++; end
    tests_run++; if (nfin !== 0) begin fails++; $display("FAIL irq_no_finish got=%0d exp=0", nfin); end
  endtask

  task automatic test_start_ignored;
    int lat; int bcnt; logic fin2;
    run32(1'b0, 32'd123, 32'd456, 1'b1, lat, bcnt, fin2);
    tests_run++; if (lat !== 33) begin fails++; $display("FAIL midstart_latency got=%0d exp=33", lat); end
    tests_run++; if ({result_hi, result, overflow} !== {32'd0, 32'd56088, 1'b0}) begin fails++;
      $display("FAIL midstart_product got hi=%h lo=%h ovf=%b exp hi=0 lo=db18 ovf=0", result_hi, result, overflow); end
    tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL midstart_no_restart got busy=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid;
    int nfin; int lat; int bcnt; logic fin2;
    @(negedge clk);
    signed_mode = 0; operand_a = 32'd77; operand_b = 32'd77; start = 1'b1;
    @(posedge clk); @(negedge clk); start = 1'b0;
    repeat (10) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    tests_run++; if ({busy, finish, overflow, result_hi, result} !== 67'd0) begin fails++;
      $display("FAIL rstmid_outputs got busy=%b fin=%b hi=%h lo=%h exp=0", busy, finish, result_hi, result); end
    reset_n = 1'b1;
    nfin = 0;
    repeat (40) begin @(negedge clk); if (finish) nfin++; end
    tests_run++; if (nfin !== 0) begin fails++; $display("FAIL rstmid_no_finish got=%0d exp=0", nfin); end
    run32(1'b1, 32'hFFFFFFF9, 32'd6, 1'b0, lat, bcnt, fin2);
    tests_run++; if ({lat, result_hi, result, overflow} !== {32'd33, 32'hFFFFFFFF, 32'hFFFFFFD6, 1'b0}) begin fails++;
      $display("FAIL rstmid_after lat=%0d hi=%h lo=%h ovf=%b exp lat=33 hi=ffffffff lo=ffffffd6 ovf=0",
               lat, result_hi, result, overflow); end
  endtask

  task automatic test_start_irq_idle;
    int nfin;
    @(negedge clk);
    signed_mode = 0; operand_a = 32'd3; operand_b = 32'd3; start = 1'b1; interrupt = 1'b1;
    @(negedge clk); start = 1'b0; interrupt = 1'b0;
    tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL idle_irq_wins got busy=%b exp=0", busy); end
    nfin = 0;
    repeat (40) begin @(negedge clk); if (finish) nfin++; end
    tests_run++; if (nfin !== 0) begin fails++; $display("FAIL idle_irq_no_finish got=%0d exp=0", nfin); end
    tests_run++; if (result !== 32'hFFFFFFD6) begin fails++;
      $display("FAIL idle_irq_result_held got=%h exp=ffffffd6", result); end
  endtask

  task automatic test_width8;
    int lat; bit done;
    @(negedge clk);
    sm8 = 1'b1; a8 = 8'h80; b8 = 8'h80; start8 = 1'b1;
    @(posedge clk); @(negedge clk); start8 = 1'b0; a8 = 8'h11; b8 = 8'h22; sm8 = 1'b0;
    lat = 0; done = 0;
    while (!done && lat < 40) begin
      if (finish8) done = 1;
      else begin @(posedge clk); @(negedge clk); lat++; end
    end
    if (!done) lat = -1;
    tests_run++; if (lat !== 9) begin fails++; $display("FAIL w8_latency got=%0d exp=9", lat); end
    tests_run++; if ({result_hi8, result8, overflow8} !== {8'h40, 8'h00, 1'b1}) begin fails++;
      $display("FAIL w8_m128sq got hi=%h lo=%h ovf=%b exp hi=40 lo=00 ovf=1", result_hi8, result8, overflow8); end
  endtask

  initial begin
    tests_run = 0; fails = 0;
    test_reset();
    test_unsigned_small();
    test_signed_neg();
    test_overflow();
    test_extremes();
    test_interrupt();
    test_start_ignored();
    test_reset_mid();
    test_start_irq_idle();
    test_width8();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
